fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-unit types: buffer entry layout, FSM states and default parameters.
package fetch_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam logic [WORD_W-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_STALL  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at the top of the 16-bit space.
  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instr}, registered head, flush clears pointers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  fetch_entry_t           i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fetch_entry_t           o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests to unified memory, buffered responses, redirect/halt control.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = DEPTH_DEF,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [WORD_W-1:0] r_pc;
  logic              r_out;
  logic [WORD_W-1:0] r_out_pc;
  logic              r_err;

  logic              w_mem_req;
  logic              w_grant;
  logic              w_push;
  logic              w_pop;
  logic              w_out_next;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_occ;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_occ_next;
  logic              w_fifo_valid;
  fetch_entry_t      w_push_data;
  fetch_entry_t      w_head;

  assign w_push_data = '{pc: r_out_pc, instr: mem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_FETCH;
      r_pc     <= RESET_PC;
      r_out    <= 1'b0;
      r_out_pc <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_out   <= w_out_next;
      if (redirect) begin
        r_pc <= redirect_pc;
      end else if (w_grant) begin
        r_pc <= pc_inc(r_pc);
      end
      if (w_grant) begin
        r_out_pc <= r_pc;
      end
      if (mem_rvalid && !r_out) begin
        r_err <= 1'b1;
      end
    end
  end

  // Request credit counts buffered words plus the one in flight, so a response always has a slot.
  always_comb begin
    w_state_next = r_state;
    w_mem_req    = 1'b0;
    w_grant      = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_out_next   = r_out;
    w_cnt_next   = w_count;
    w_occ        = w_count + CNT_W'(r_out);
    w_occ_next   = '0;

    w_mem_req  = reset && (r_state == ST_FETCH) && !halt && !redirect
                 && (w_occ < CNT_W'(DEPTH));
    w_grant    = w_mem_req && mem_gnt;
    w_push     = mem_rvalid && r_out && !redirect;
    w_pop      = w_fifo_valid && instr_ready && !redirect;
    w_out_next = w_grant || (r_out && !mem_rvalid);

    if (redirect) begin
      w_cnt_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_cnt_next = w_count + CNT_W'(1);
        2'b01:   w_cnt_next = w_count - CNT_W'(1);
        default: w_cnt_next = w_count;
      endcase
    end
    w_occ_next = w_cnt_next + CNT_W'(w_out_next);

    if (halt) begin
      w_state_next = ST_HALTED;
    end else if (w_occ_next == CNT_W'(DEPTH)) begin
      w_state_next = ST_STALL;
    end else begin
      w_state_next = ST_FETCH;
    end
  end

  assign mem_req     = w_mem_req;
  assign mem_addr    = r_pc;
  assign instr_valid = w_fifo_valid;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign err         = r_err;

endmodule
